// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - registered immediate/data extender with valid/ready and one-entry skid buffer
module ext_pipe #(
  parameter int IN_W      = 16,
  parameter int OUT_W     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_imm,
  input  logic [2:0]           in_mode,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int H = OUT_W - IN_W;

  logic [OUT_W-1:0] zext, sext, res_data;
  logic             res_err;
  logic             accept, load;
  logic             skid_valid;
  logic [OUT_W-1:0] skid_data;
  logic             skid_err;

  assign zext = {{H{1'b0}}, in_imm};
  assign sext = {{H{in_imm[IN_W-1]}}, in_imm};

  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (in_mode)
      3'd0:    res_data = zext;
      3'd1:    res_data = sext;
      3'd2:    res_data = zext << H;
      3'd3:    res_data = {{(OUT_W-8){in_imm[7]}}, in_imm[7:0]};
      3'd4:    res_data = {{(OUT_W-8){1'b0}}, in_imm[7:0]};
      3'd5:    res_data = sext << 2;
      default: res_err  = 1'b1;
    endcase
  end

  // in_ready comes straight from the skid flop, so it never depends on out_ready combinationally.
  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready & ~flush;
  assign load     = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_err    <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_err   <= 1'b0;
      err_cnt    <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (load) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_data   <= skid_data;
          out_err    <= skid_err;
          skid_valid <= 1'b0;
        end else if (accept) begin
          out_valid <= 1'b1;
          out_data  <= res_data;
          out_err   <= res_err;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_valid <= 1'b1;
        skid_data  <= res_data;
        skid_err   <= res_err;
      end
      if (accept && res_err && !(&err_cnt))
        err_cnt <= err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - scoreboard bench for ext_pipe
module tb_ext_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_mode;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;
  logic [1:0]  err_cnt;

  int checks   = 0;
  int failures = 0;
  logic [32:0] sb_q[$];

  ext_pipe #(.IN_W(16), .OUT_W(32), .ERR_CNT_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [2:0] m, input logic [15:0] e);
    case (m)
      3'd0:    return {1'b0, 16'h0000, e};
      3'd1:    return {1'b0, {16{e[15]}}, e};
      3'd2:    return {1'b0, e, 16'h0000};
      3'd3:    return {1'b0, {24{e[7]}}, e[7:0]};
      3'd4:    return {1'b0, 24'h000000, e[7:0]};
      3'd5:    return {1'b0, {14{e[15]}}, e, 2'b00};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Called at a falling edge: drives inputs, scores the coming rising edge, returns at the next falling edge.
  task automatic step(input logic v, input logic [2:0] m, input logic [15:0] imm,
                      input logic ordy, input logic fl);
    logic [32:0] e;
    in_valid = v; in_mode = m; in_imm = imm; out_ready = ordy; flush = fl;
    #1;
    if (!fl && out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected_beat", 64'(out_data), 64'hdead);
      else begin
        e = sb_q.pop_front();
        chk("sb_data", 64'(out_data), 64'(e[31:0]));
        chk("sb_err", 64'(out_err), 64'(e[32]));
      end
    end
    if (v && in_ready && !fl) sb_q.push_back(model(m, imm));
    if (fl) sb_q.delete();
    @(negedge clk);
  endtask

  logic [2:0]  t_mode [4] = '{3'd2, 3'd5, 3'd3, 3'd4};
  logic [15:0] t_imm  [4] = '{16'h1234, 16'hFFFF, 16'h0080, 16'h00FF};
  logic [31:0] t_exp  [4] = '{32'h12340000, 32'hFFFFFFFC, 32'hFFFFFF80, 32'h000000FF};

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_imm = '0; in_mode = '0; flush = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_err", 64'(out_err), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // sign extension, one-cycle latency
    step(1'b1, 3'd1, 16'h8000, 1'b1, 1'b0);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_data", 64'(out_data), 64'hFFFF8000);
    chk("t1_out_err", 64'(out_err), 64'd0);

    for (int i = 0; i < 4; i++) begin
      step(1'b1, t_mode[i], t_imm[i], 1'b1, 1'b0);
      chk("t2_mode_data", 64'(out_data), 64'(t_exp[i]));
    end
    step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    chk("t2_idle_valid", 64'(out_valid), 64'd0);

    // stall fills the skid, then drains in order
    step(1'b1, 3'd0, 16'h0001, 1'b0, 1'b0);
    step(1'b1, 3'd0, 16'h0002, 1'b0, 1'b0);
    chk("t3_in_ready_full", 64'(in_ready), 64'd0);
    chk("t3_hold_a", 64'(out_data), 64'd1);
    step(1'b1, 3'd0, 16'h0003, 1'b0, 1'b0);
    chk("t3_hold_stable", 64'(out_data), 64'd1);
    step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    chk("t3_b_next", 64'(out_data), 64'd2);
    chk("t3_in_ready_back", 64'(in_ready), 64'd1);
    step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    chk("t3_drained", 64'(out_valid), 64'd0);

    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'd6, 16'(i), 1'b1, 1'b0);
      chk("t4_err_cnt", 64'(err_cnt), (i < 3) ? 64'(i + 1) : 64'd3);
      chk("t4_out_err", 64'(out_err), 64'd1);
    end
    step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);

    // flush with a full pipe and an illegal beat offered
    step(1'b1, 3'd0, 16'h0011, 1'b0, 1'b0);
    step(1'b1, 3'd0, 16'h0022, 1'b0, 1'b0);
    step(1'b1, 3'd7, 16'h0033, 1'b0, 1'b1);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_err_cnt", 64'(err_cnt), 64'd3);
    step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);
    chk("t5_no_ghost", 64'(out_valid), 64'd0);
    step(1'b1, 3'd0, 16'h0044, 1'b1, 1'b0);
    step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);

    // async reset with out and skid both occupied
    step(1'b1, 3'd1, 16'h1234, 1'b0, 1'b0);
    step(1'b1, 3'd0, 16'h0055, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_err_cnt", 64'(err_cnt), 64'd0);
    chk("t6_in_ready", 64'(in_ready), 64'd1);
    sb_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1, 3'd0, 16'h0077, 1'b1, 1'b0);
    chk("t6_first_valid", 64'(out_valid), 64'd1);
    chk("t6_first_data", 64'(out_data), 64'h77);
    step(1'b0, 3'd0, 16'h0, 1'b1, 1'b0);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
